// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline control block: the 2-bit FSM state
// encoding, the hazard bubble-count encoding, the drain depth used when
// halting, and a helper that maps a hazard type to its bubble count.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    // HAZ_DEFAULT (0) is treated as a single bubble.
    typedef enum logic [1:0] {
        HAZ_DEFAULT = 2'd0,
        HAZ_ONE     = 2'd1,
        HAZ_TWO     = 2'd2,
        HAZ_THREE   = 2'd3
    } haz_type_e;

    // Instructions already past IF that must retire before the core stops.
    localparam logic [1:0] DRAIN_DEPTH = 2'd3;

    localparam int STALL_CNT_W = 32;

    function automatic logic [1:0] bubble_count(input logic [1:0] haz_type);
        return (haz_type == HAZ_DEFAULT) ? 2'(HAZ_ONE) : haz_type;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat.sv
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low clear (count -> 0)
//   en       - count one step this edge
//   load     - overwrite count with load_val (takes precedence over en)
//   load_val - value written on load
//   count    - current count
module sat_counter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != {DATA_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central pipeline sequencer for a 5-stage core. Turns hazard, branch,
// memory-wait and halt requests into PC / stage-register enables and
// IF/ID, ID/EX flushes, and counts stalled cycles.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   haz_stall         - load-use (or similar) hazard present
//   haz_type          - bubbles requested (0 means 1)
//   branch_taken      - taken branch/jump resolved in EX
//   dmem_busy         - data memory not ready, freezes the whole pipe
//   halt_req          - EBREAK/ECALL decoded in ID
//   resume            - leave the halted state
//   pc_en, *_en       - PC and pipeline register enables
//   if_id_flush,
//   id_ex_flush       - load a NOP into that stage register
//   halted            - pipeline drained and stopped
//   stall_cycles      - saturating count of PC-frozen cycles in RUN/BUBBLE
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   haz_stall,
    input  logic [1:0]             haz_type,
    input  logic                   branch_taken,
    input  logic                   dmem_busy,
    input  logic                   halt_req,
    input  logic                   resume,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    state_e     state, state_next;
    logic [1:0] bub_cnt, bub_next;
    logic [1:0] drain_cnt, drain_next;
    logic [1:0] bub_req;
    logic       stall_en;

    assign bub_req = bubble_count(haz_type);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            bub_cnt   <= 2'd0;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            bub_cnt   <= bub_next;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        state_next  = state;
        bub_next    = bub_cnt;
        drain_next  = drain_cnt;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = (state == ST_HALTED);

        if (state == ST_HALTED) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
            if (resume) begin
                state_next = ST_RUN;
            end
        end else if (dmem_busy) begin
            // Whole pipe frozen; sequencing counters keep their place.
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        bub_next    = 2'd0;
                    end else if (halt_req) begin
                        // Stop fetching and let the older instructions retire.
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        drain_next  = DRAIN_DEPTH;
                        state_next  = ST_DRAIN;
                    end else if (haz_stall) begin
                        // This cycle is the first bubble; any further ones
                        // are counted out in BUBBLE.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        if (bub_req > 2'd1) begin
                            bub_next   = bub_req - 2'd1;
                            state_next = ST_BUBBLE;
                        end
                    end
                end
                ST_BUBBLE: begin
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        bub_next    = 2'd0;
                        state_next  = ST_RUN;
                    end else begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        bub_next    = bub_cnt - 2'd1;
                        if (bub_cnt <= 2'd1) begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (branch_taken) begin
                        // Squash the wrong-path fetch but keep draining.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        drain_next  = drain_cnt - 2'd1;
                        if (drain_cnt <= 2'd1) begin
                            state_next = ST_HALTED;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_en = ((state == ST_RUN) || (state == ST_BUBBLE)) && !pc_en;

    sat_counter #(
        .DATA_W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (stall_en),
        .load     (1'b0),
        .load_val ({STALL_CNT_W{1'b0}}),
        .count    (stall_cycles)
    );

endmodule
